// File: rtl/regfile_wb_decoder_pkg.sv
// Shared constants and types for the register-file write-back path.
// The commit-stage record lives here so every file agrees on its layout.
package regfile_wb_decoder_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } commit_t;

endpackage

// File: rtl/regfile_wb_decoder_if.sv
// Write-back / operand-fetch bundle between the pipeline and the register file.
// The master is the pipeline side; the slave is the register file.
interface regfile_wb_decoder_if;
  import regfile_wb_decoder_pkg::*;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_a;
  logic [DATA_W-1:0]   rd_data_b;
  logic [NUM_REGS-1:0] wr_onehot;
  logic                wb_busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_onehot, wb_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_onehot, wb_busy
  );

endinterface

// File: rtl/regfile_wb_decoder_decoder_5to32.sv
// Register-number to one-hot write-enable decoder. Register 0 is hardwired
// zero, so its bit is never asserted.
module decoder_5to32
  import regfile_wb_decoder_pkg::*;
(
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);

  logic w_en_nonzero;

  assign w_en_nonzero = i_en && (i_addr != ZERO_REG);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      assign o_onehot[gi] = w_en_nonzero && (i_addr == ADDR_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/regfile_wb_decoder.sv
// 32x32 register file with a one-cycle write commit stage and two registered
// read ports with write-through bypass from the incoming write and the commit stage.
module regfile_wb_decoder
  import regfile_wb_decoder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_decoder_if.slave  bus
);

  commit_t             r_cm;
  logic [NUM_REGS-1:0] r_wr_onehot;
  logic [NUM_REGS-1:0] w_dec_onehot;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [ADDR_W-1:0]   w_rd_addr [2];
  logic [DATA_W-1:0]   w_rd_next [2];
  logic [DATA_W-1:0]   r_rd_data [2];

  decoder_5to32 u_dec (
    .i_en     (bus.wr_en),
    .i_addr   (bus.wr_addr),
    .o_onehot (w_dec_onehot)
  );

  // Commit stage: holds the write for one cycle before it lands in the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cm        <= '0;
      r_wr_onehot <= '0;
    end else begin
      r_cm.vld    <= bus.wr_en;
      r_cm.addr   <= bus.wr_addr;
      r_cm.data   <= bus.wr_data;
      r_wr_onehot <= w_dec_onehot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (r_wr_onehot[i]) begin
          r_regs[i] <= r_cm.data;
        end
      end
    end
  end

  assign w_rd_addr[0] = bus.rd_addr_a;
  assign w_rd_addr[1] = bus.rd_addr_b;

  // Newest write wins: incoming write, then commit stage, then the array.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign w_rd_next[gi] =
        (w_rd_addr[gi] == ZERO_REG)                          ? '0          :
        (bus.wr_en && (bus.wr_addr == w_rd_addr[gi]))        ? bus.wr_data :
        (r_cm.vld && (r_cm.addr == w_rd_addr[gi]))           ? r_cm.data   :
                                                               r_regs[w_rd_addr[gi]];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data[0] <= '0;
      r_rd_data[1] <= '0;
    end else begin
      r_rd_data[0] <= w_rd_next[0];
      r_rd_data[1] <= w_rd_next[1];
    end
  end

  assign bus.rd_data_a = r_rd_data[0];
  assign bus.rd_data_b = r_rd_data[1];
  assign bus.wr_onehot = r_wr_onehot;
  assign bus.wb_busy   = r_cm.vld;

endmodule

// File: tb/tb_regfile_wb_decoder.sv
// Bench for regfile_wb_decoder: reset checks, a directed vector table and a
// randomized run against an architectural register-file model.
module tb_regfile_wb_decoder;
  import regfile_wb_decoder_pkg::*;

  logic clk;
  logic rst_n;
  regfile_wb_decoder_if bus ();

  regfile_wb_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Architectural view: a write is visible to any read issued in the same cycle or later.
  logic [31:0] mem [32];
  logic [31:0] exp_a, exp_b, exp_oh;
  logic        exp_busy;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] eoh;
    logic        ebusy;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask

  // Apply one cycle of inputs, update the model, then sample outputs after the edge.
  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    if (we && wa != 5'd0) mem[wa] = wd;
    exp_a    = (ra == 5'd0) ? 32'd0 : mem[ra];
    exp_b    = (rb == 5'd0) ? 32'd0 : mem[rb];
    exp_oh   = (we && wa != 5'd0) ? (32'd1 << wa) : 32'd0;
    exp_busy = we;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_a"},   bus.rd_data_a, 32'd0);
    check({tag, " rd_b"},   bus.rd_data_b, 32'd0);
    check({tag, " onehot"}, bus.wr_onehot, 32'd0);
    check({tag, " busy"},   {31'd0, bus.wb_busy}, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_clear();

    // Reset held while a write is presented.
    rst_n         = 1'b0;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd5;
    bus.wr_data   = 32'h5555_5555;
    bus.rd_addr_a = 5'd5;
    bus.rd_addr_b = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    check("post-reset r5 a", bus.rd_data_a, 32'd0);
    check("post-reset r5 b", bus.rd_data_b, 32'd0);

    //           we    wa     wd            ra     rb     ea            eb            eoh           busy
    vecs[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd0,  5'd0,  32'd0,        32'd0,        32'h0000_0080, 1'b1};
    vecs[1]  = '{1'b0, 5'd0,  32'd0,        5'd7,  5'd5,  32'hDEADBEEF, 32'd0,        32'd0,         1'b0};
    vecs[2]  = '{1'b1, 5'd3,  32'h11,       5'd3,  5'd7,  32'h11,       32'hDEADBEEF, 32'h0000_0008, 1'b1};
    vecs[3]  = '{1'b0, 5'd0,  32'd0,        5'd7,  5'd3,  32'hDEADBEEF, 32'h11,       32'd0,         1'b0};
    vecs[4]  = '{1'b1, 5'd9,  32'hA,        5'd9,  5'd0,  32'hA,        32'd0,        32'h0000_0200, 1'b1};
    vecs[5]  = '{1'b1, 5'd9,  32'hB,        5'd9,  5'd9,  32'hB,        32'hB,        32'h0000_0200, 1'b1};
    vecs[6]  = '{1'b0, 5'd0,  32'd0,        5'd9,  5'd3,  32'hB,        32'h11,       32'd0,         1'b0};
    vecs[7]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'd0,        32'd0,        32'd0,         1'b1};
    vecs[8]  = '{1'b0, 5'd0,  32'd0,        5'd0,  5'd9,  32'd0,        32'hB,        32'd0,         1'b0};
    vecs[9]  = '{1'b1, 5'd31, 32'h12345678, 5'd31, 5'd30, 32'h12345678, 32'd0,        32'h8000_0000, 1'b1};
    vecs[10] = '{1'b1, 5'd1,  32'hCAFEF00D, 5'd31, 5'd1,  32'h12345678, 32'hCAFEF00D, 32'h0000_0002, 1'b1};
    vecs[11] = '{1'b0, 5'd0,  32'd0,        5'd1,  5'd7,  32'hCAFEF00D, 32'hDEADBEEF, 32'd0,         1'b0};

    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra, vecs[v].rb);
      $display("vec %0d: we=%0b wa=%0d wd=%h ra=%0d rb=%0d -> a=%h b=%h oh=%h busy=%0b",
               v, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra, vecs[v].rb,
               bus.rd_data_a, bus.rd_data_b, bus.wr_onehot, bus.wb_busy);
      check($sformatf("vec%0d rd_a", v),   bus.rd_data_a, vecs[v].ea);
      check($sformatf("vec%0d rd_b", v),   bus.rd_data_b, vecs[v].eb);
      check($sformatf("vec%0d onehot", v), bus.wr_onehot, vecs[v].eoh);
      check($sformatf("vec%0d busy", v),   {31'd0, bus.wb_busy}, {31'd0, vecs[v].ebusy});
    end

    // r9 still holds the later write several cycles on.
    repeat (3) drive(1'b0, 5'd0, 32'd0, 5'd2, 5'd4);
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    check("r9 late", bus.rd_data_a, 32'hB);
    check("r0 late", bus.rd_data_b, 32'd0);

    // Asynchronous reset while a write sits in the commit stage.
    drive(1'b1, 5'd7, 32'h0BAD_0BAD, 5'd1, 5'd2);
    check("pre-async busy", {31'd0, bus.wb_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async");
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    drive(1'b0, 5'd0, 32'd0, 5'd7, 5'd9);
    check("post-async r7", bus.rd_data_a, 32'd0);
    check("post-async r9", bus.rd_data_b, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd31);
    check("post-async r1", bus.rd_data_a, 32'd0);
    check("post-async r31", bus.rd_data_b, 32'd0);

    // Randomized traffic with forced address collisions.
    begin
      logic [4:0] last_wa;
      last_wa = 5'd0;
      for (int c = 0; c < 10000; c++) begin
        logic        we;
        logic [4:0]  wa, ra, rb;
        logic [31:0] wd;
        we = ($urandom_range(0, 3) != 0);
        wa = 5'($urandom_range(0, 31));
        wd = $urandom;
        ra = 5'($urandom_range(0, 31));
        rb = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) ra = wa;
        if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 0) ? wa : last_wa;
        if (we) last_wa = wa;
        drive(we, wa, wd, ra, rb);
        check($sformatf("rand%0d rd_a", c),   bus.rd_data_a, exp_a);
        check($sformatf("rand%0d rd_b", c),   bus.rd_data_b, exp_b);
        check($sformatf("rand%0d onehot", c), bus.wr_onehot, exp_oh);
        check($sformatf("rand%0d busy", c),   {31'd0, bus.wb_busy}, {31'd0, exp_busy});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
